// File: rtl/cpu_trace_extractor.sv
// cpu_trace_extractor: decodes the numeric fields of cpu_checker trace lines
// (time, PC, GRF number or memory address, write data) and queues one record
// per line that cpu_checker accepts into a small show-ahead FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | outside a line, waiting for '^'
// TIME    | accumulating the decimal time stamp
// PC      | accumulating the hex PC
// SEP     | after ':', waiting for '$' (register) or '*' (memory)
// GRF     | accumulating the decimal GRF number
// ADDR    | accumulating the hex memory address
// ARROW   | inside "<=" and spaces, waiting for the first data digit
// DATA    | accumulating the hex write data
// DONE    | '#' seen; cpu_checker's verdict arrives in this cycle
module cpu_trace_extractor #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               char,
  input  logic [1:0]               format_type,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               rec_type,
  output logic [13:0]              rec_time,
  output logic [31:0]              rec_pc,
  output logic [31:0]              rec_dst,
  output logic [31:0]              rec_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_TIME  = 4'd1;
  localparam logic [3:0] S_PC    = 4'd2;
  localparam logic [3:0] S_SEP   = 4'd3;
  localparam logic [3:0] S_GRF   = 4'd4;
  localparam logic [3:0] S_ADDR  = 4'd5;
  localparam logic [3:0] S_ARROW = 4'd6;
  localparam logic [3:0] S_DATA  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  typedef struct packed {
    logic [1:0]  typ;
    logic [13:0] tim;
    logic [31:0] pc;
    logic [31:0] dst;
    logic [31:0] data;
  } rec_t;

  logic [3:0]  state, state_nxt;
  logic [13:0] acc_t, acc_g;
  logic [31:0] acc_pc, acc_a, acc_data;

  logic        is_dec, is_hex, is_caret;
  logic [3:0]  nib;
  logic [3:0]  dec_d;

  rec_t          mem [DEPTH];
  rec_t          rec_in, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, wr_en;

  // character classification; only lowercase a-f count as hex letters
  always_comb begin
    is_caret = (char == "^");
    is_dec   = (char >= "0") && (char <= "9");
    is_hex   = is_dec || ((char >= "a") && (char <= "f"));
    dec_d    = char[3:0];
    nib      = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

  // field state machine next-state; '^' restarts a line from any state
  always_comb begin
    state_nxt = S_IDLE;
    if (is_caret) begin
      state_nxt = S_TIME;
    end else begin
      case (state)
        S_TIME:  if (is_dec) state_nxt = S_TIME;
                 else if (char == "@") state_nxt = S_PC;
        S_PC:    if (is_hex) state_nxt = S_PC;
                 else if (char == ":") state_nxt = S_SEP;
        S_SEP:   if (char == " ") state_nxt = S_SEP;
                 else if (char == "$") state_nxt = S_GRF;
                 else if (char == "*") state_nxt = S_ADDR;
        S_GRF:   if (is_dec || char == " ") state_nxt = S_GRF;
                 else if (char == "<") state_nxt = S_ARROW;
        S_ADDR:  if (is_hex || char == " ") state_nxt = S_ADDR;
                 else if (char == "<") state_nxt = S_ARROW;
        S_ARROW: if (char == "=" || char == " ") state_nxt = S_ARROW;
                 else if (is_hex) state_nxt = S_DATA;
        S_DATA:  if (is_hex) state_nxt = S_DATA;
                 else if (char == "#") state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // state register and field accumulators; '^' clears them on the same edge
  // that a pending DONE record is pushed, so the push sees pre-clear values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      acc_t    <= '0;
      acc_g    <= '0;
      acc_pc   <= '0;
      acc_a    <= '0;
      acc_data <= '0;
    end else begin
      state <= state_nxt;
      if (is_caret) begin
        acc_t    <= '0;
        acc_g    <= '0;
        acc_pc   <= '0;
        acc_a    <= '0;
        acc_data <= '0;
      end else begin
        case (state)
          S_TIME:  if (is_dec) acc_t <= acc_t * 14'd10 + {10'd0, dec_d};
          S_PC:    if (is_hex) acc_pc <= {acc_pc[27:0], nib};
          S_GRF:   if (is_dec) acc_g <= acc_g * 14'd10 + {10'd0, dec_d};
          S_ADDR:  if (is_hex) acc_a <= {acc_a[27:0], nib};
          S_ARROW, S_DATA: if (is_hex) acc_data <= {acc_data[27:0], nib};
          default: ;
        endcase
      end
    end
  end

  // record assembly and FIFO control; a pop while full frees room for a push
  always_comb begin
    rec_in.typ  = format_type;
    rec_in.tim  = acc_t;
    rec_in.pc   = acc_pc;
    rec_in.dst  = (format_type == 2'b01) ? {18'd0, acc_g} : acc_a;
    rec_in.data = acc_data;
    push        = (state == S_DONE) && (format_type != 2'b00);
    out_valid   = (count != '0);
    pop         = out_valid && out_ready;
    full        = (count == CW'(DEPTH));
    wr_en       = push && (!full || pop);
  end

  // record FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= rec_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // show-ahead head view, forced to zero while empty
  always_comb begin
    head     = mem[rd_ptr];
    rec_type = out_valid ? head.typ  : '0;
    rec_time = out_valid ? head.tim  : '0;
    rec_pc   = out_valid ? head.pc   : '0;
    rec_dst  = out_valid ? head.dst  : '0;
    rec_data = out_valid ? head.data : '0;
  end

endmodule

// File: doc/cpu_trace_extractor.md
# cpu_trace_extractor

- Sits directly downstream of `cpu_checker` and sees the same `char` stream in the same cycles.
- Pulls the numeric fields out of each trace line: time, PC, GRF number or memory address, and write data.
- When `cpu_checker` flags a completed, well-formed line through `format_type`, the block pushes one decoded record into a small show-ahead FIFO.
- A consumer drains that FIFO with a valid/ready handshake.

## Interface
- `DEPTH`, 4: record FIFO depth, power of two, at least 2.
- `clk`  input  1  single clock; everything is rising-edge.
- `reset`  input  1  asynchronous, active-low. 0 clears all state immediately.
- `char`  input  8  ASCII character. Identical to `cpu_checker.char`, same cycle.
- `format_type`  input  2  taken from `cpu_checker`. 01 = register line, 10 = memory line, 00 = none.
- `out_valid`  output  1  FIFO is non-empty.
- `out_ready`  input  1  consumer accepts the head record on a cycle where `out_valid & out_ready`.
- `rec_type`  output  2  head record type (01 or 10).
- `rec_time`  output  14  decimal time value.
- `rec_pc`  output  32  PC.
- `rec_dst`  output  32  GRF number (zero-extended) for a register line, or address for a memory line.
- `rec_data`  output  32  write data.
- `count`  output  log2(DEPTH)+1  number of records held.
- `overflow`  output  1  sticky; set when a record is dropped because the FIFO is full.

## Operation
Character classes:
- Hex digit: `0`–`9` and lowercase `a`–`f` only.
- Decimal digit: `0`–`9`.

Field state machine. States: IDLE, TIME, PC, SEP, GRF, ADDR, ARROW, DATA, DONE.
- `^` in any state: go to TIME and clear all accumulators.
- IDLE: every other character is ignored.
- TIME: a decimal digit updates `t <= t*10 + d`, wrapping mod 2^14. `@` goes to PC.
- PC: a hex digit updates `pc <= {pc[27:0], nib}`. `:` goes to SEP.
- SEP: a space stays. `$` goes to GRF. `*` goes to ADDR.
- GRF: a decimal digit updates `g <= g*10 + d`, mod 2^14. A space stays. `<` goes to ARROW.
- ADDR: a hex digit shifts into `a`. A space stays. `<` goes to ARROW.
- ARROW: `=` or a space stays. A hex digit shifts into `data` and goes to DATA.
- DATA: a hex digit shifts into `data`. `#` goes to DONE.
- DONE: any character other than `^` goes to IDLE.
- Every state except IDLE: a character not listed goes to IDLE. Accumulators are kept but never used.
- Format validation is entirely `cpu_checker`'s job. This block never rejects a line by itself.

Record push:
- Push condition: state == DONE and `format_type != 00` in the same cycle.
- Push happens at that cycle's clock edge.
- Record contents: `{format_type, t, pc, (format_type==01 ? g zero-extended : a), data}`.
- DONE with `format_type == 00`: no push.
- A `^` in the push cycle is legal. The push captures the pre-clear values. The clear and the new TIME state take effect on the same edge.

FIFO:
- Show-ahead: `rec_*` always shows the head entry.
- `rec_*` are all zero when empty.
- Push while full and no pop: the record is dropped and `overflow` is set. `overflow` clears only on reset.
- Push and pop together while full: both take effect and `count` is unchanged.
- Push and pop together while empty: the push is accepted and the pop is ignored, because `out_valid` is 0.
- Read and write pointers wrap mod DEPTH.

## Timing
- `cpu_checker` registers its state on the `#` edge, so `format_type` is valid during the cycle after `#` is presented. That cycle is the DONE cycle.
- Latency: `#` presented in cycle N. Record pushed at the end of cycle N+1. `out_valid` rises in cycle N+2.
- Throughput: one record per line. The minimum line length guarantees the FIFO never sees two pushes in one cycle.
- Pop: the head advances on the edge where `out_valid & out_ready`. The next record, or zeros, is visible in the following cycle.
- Reset values: state IDLE, accumulators 0, `count` 0, `out_valid` 0, `rec_*` 0, `overflow` 0.
- Reset asserted mid-line: the partial line is discarded. After release, the next `^` starts cleanly.

## Test plan
- Register line: `^10@00003000: $1 <= 0000abcd#`, with `format_type` 01 driven the cycle after `#`. Required: cycle N+2 shows `out_valid`=1, `rec_type`=01, `rec_time`=10, `rec_pc`=0x00003000, `rec_dst`=1, `rec_data`=0x0000abcd.
- Memory line: `^2345@00003004: *0000001c <= deadbeef#`, with `format_type` 10. Required: `rec_type`=10, `rec_time`=2345, `rec_dst`=0x0000001c, `rec_data`=0xdeadbeef.
- Rejected line: `^5@0000300: $1<=00000001#` with `format_type` held at 00. Required: `out_valid` stays 0 and `count` stays 0.
- Restart: `^1@00003000: $2 <= 00` then immediately `^7@00003008: $3 <= 00000005#`, with `format_type` 01. Required: exactly one record, time 7, pc 0x00003008, dst 3, data 5.
- Overflow: 5 valid register lines with `out_ready`=0 and DEPTH=4. Required: `count`=4, `overflow`=1, head is the first record. Then raise `out_ready` for 4 cycles: records 1–4 come out in order and `overflow` stays 1.
- Reset: drive `reset`=0 in the middle of a DATA field. Required: all outputs read 0 immediately, and a following complete line yields one correct record.
